// File: rtl/audio_clip_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_clip_streamer                                          |
// | Description : Streams one clip (base + length) from a synchronous sample   |
// |               memory at a programmable sample rate. Supports one-shot or   |
// |               loop playback, abort, and a valid/ready output handshake.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module audio_clip_streamer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int TICK_DIV = 2268
) (
  input  logic              sysclock,
  input  logic              sysreset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] clip_base,
  input  logic [ADDR_W-1:0] clip_len,
  input  logic              loop_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                c_cnt_w     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_READ      = 3'd2,
    S_CAPTURE   = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                loop_q, loop_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic                done_q, done_d;

  logic                w_tick;
  logic [ADDR_W-1:0]   w_last_off;

  // The sample-period tick only exists while a clip is active
  assign w_tick     = (state_q != S_IDLE) && (cnt_q == c_tick_last);
  assign w_last_off = len_q - ADDR_W'(1);

  // Next-state and next-output computation for the playback engine
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    offset_d       = offset_q;
    base_d         = base_q;
    len_d          = len_q;
    loop_d         = loop_q;
    pending_d      = pending_q;
    overrun_d      = overrun_q;
    mem_re_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = sample_valid_q;
    done_d         = 1'b0;

    // Sample-period counter free-runs while busy, wrapping at TICK_DIV-1
    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == c_tick_last) ? '0 : cnt_q + 1'b1;
    end

    // A tick that cannot be served now is remembered once; a second one is lost
    if (w_tick && (state_q != S_WAIT_TICK)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        pending_d = 1'b0;
        if (start) begin
          if (clip_len != '0) begin
            base_d    = clip_base;
            len_d     = clip_len;
            loop_d    = loop_en;
            offset_d  = '0;
            overrun_d = 1'b0;
            state_d   = S_WAIT_TICK;
          end else begin
            // Empty clip finishes immediately without touching memory
            done_d = 1'b1;
          end
        end
      end

      S_WAIT_TICK: begin
        if (w_tick || pending_q) begin
          pending_d  = 1'b0;
          mem_re_d   = 1'b1;
          mem_addr_d = base_q + offset_q;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        sample_out_d   = mem_rdata;
        sample_valid_d = 1'b1;
        state_d        = S_HOLD;
      end

      S_HOLD: begin
        if (sample_valid_q && sample_ready) begin
          sample_valid_d = 1'b0;
          if (offset_q != w_last_off) begin
            offset_d = offset_q + 1'b1;
            state_d  = S_WAIT_TICK;
          end else if (loop_q) begin
            offset_d = '0;
            state_d  = S_WAIT_TICK;
          end else begin
            done_d       = 1'b1;
            sample_out_d = '0;
            cnt_d        = '0;
            pending_d    = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other event while busy; overrun is kept for inspection
    if (stop && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      cnt_d          = '0;
      pending_d      = 1'b0;
      overrun_d      = overrun_q;
      mem_re_d       = 1'b0;
      sample_valid_d = 1'b0;
      sample_out_d   = '0;
      done_d         = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sysclock) begin
    if (sysreset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      offset_q       <= '0;
      base_q         <= '0;
      len_q          <= '0;
      loop_q         <= 1'b0;
      pending_q      <= 1'b0;
      overrun_q      <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      offset_q       <= offset_d;
      base_q         <= base_d;
      len_q          <= len_d;
      loop_q         <= loop_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_re       = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: doc/audio_clip_streamer.md
Name: audio_clip_streamer

Overview:
- Parametrised successor to the single-clip sample reader.
- Streams one selectable clip (base address plus length) out of an external synchronous sample memory at a programmable sample rate.
- Supports one-shot or loop playback, abort, and a valid/ready output handshake to the audio mixer/DAC path.
- Sits between the game control unit (start/stop, clip select) and the M10K sample ROM.

Parameters:
- DATA_W, 8, sample width in bits.
- ADDR_W, 17, memory address width; also the clip base and length width.
- TICK_DIV, 2268, sysclock cycles per sample period (50 MHz / 22.05 kHz); legal range is 4 or more.

Ports:
- sysclock  in  1  system clock; all logic is on the rising edge.
- sysreset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches clip_base, clip_len and loop_en; honoured in IDLE only.
- stop  in  1  abort playback; honoured in any busy state.
- clip_base  in  ADDR_W  first sample address of the clip.
- clip_len  in  ADDR_W  number of samples in the clip.
- loop_en  in  1  1 = restart the clip at clip_base after its last sample.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re.
- sample_out  out  DATA_W  current sample.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  consumer accepts the sample when valid and ready are both 1.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle pulse at the natural end of a one-shot clip.
- overrun  out  1  sticky; a sample period was lost to backpressure.

Behaviour:
- Reset (sysreset=1 at a clock edge): state goes to IDLE. offset, tick counter, pending flag and latched clip registers clear to 0. All outputs are 0, including sample_out and overrun. Reset overrides start and stop, and aborts any in-flight read.
- State machine:
  - IDLE: start=1 with clip_len≠0 → latch inputs, offset=0, tick counter=0, overrun=0 → WAIT_TICK. start=1 with clip_len=0 → done=1 on the next cycle, remain in IDLE. stop is ignored in IDLE.
  - WAIT_TICK: on tick or pending flag set → READ; clear pending.
  - READ: exactly one cycle; mem_re=1, mem_addr = (base + offset) mod 2^ADDR_W → CAPTURE.
  - CAPTURE: sample_out ← mem_rdata; sample_valid=1 from the next cycle → HOLD.
  - HOLD: on valid and ready → sample_valid=0 next cycle, then advance:
    - offset < len−1: offset+1 → WAIT_TICK.
    - offset = len−1 with loop_en=1: offset=0 → WAIT_TICK.
    - offset = len−1 with loop_en=0: done=1 for one cycle, sample_out=0 → IDLE.
- Tick counter:
  - Free-runs 0..TICK_DIV−1 while busy.
  - tick=1 in the cycle the counter equals TICK_DIV−1; the counter then wraps to 0.
  - The counter is held at 0 in IDLE.
  - The first tick occurs TICK_DIV cycles after start.
- Latency: tick in cycle T (in WAIT_TICK) gives mem_re in T+1 and sample_valid in T+3.
- Backpressure:
  - A tick outside WAIT_TICK sets the pending flag (one deep).
  - A tick while pending is already set sets overrun. overrun stays 1 until the next accepted start or reset.
  - Samples are never skipped; playback simply slips.
- stop in a busy state: next cycle is IDLE, with sample_valid=0, sample_out=0, pending=0 and mem_re=0. done is not asserted; overrun is retained.
- Simultaneous events: stop beats start. start in a busy state is ignored. stop in the same cycle as the last-sample handshake → IDLE, with no done.
- Inputs clip_base, clip_len and loop_en are sampled only at the accepted start; later changes have no effect until the next start.
- mem_re is 1 only in READ; mem_addr holds its last value otherwise (0 after reset).

Test Plan:
- Basic one-shot: TICK_DIV=4, ROM[a]=a[7:0], ready tied 1, start with base=0x10, len=4, loop=0 → sample_out sequence 0x10, 0x11, 0x12, 0x13, each valid 1 cycle; first valid 7 cycles after start; done pulses once, then busy=0, sample_out=0.
- Loop: base=0x20, len=3, loop=1, run 8 samples → sequence 0x20, 0x21, 0x22, 0x20, 0x21, 0x22, 0x20, 0x21; no done; stop → busy=0 next cycle, no done.
- Backpressure: TICK_DIV=4, hold ready=0 for 3 cycles → overrun stays 0 and the next sample issues immediately from the pending flag; hold ready=0 for 10 cycles → overrun=1, sequence intact, no skipped address; next start clears overrun.
- Edge lengths: len=0 → done on the next cycle, no mem_re; len=1 → exactly one sample; base=2^17−2, len=4 → mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset and overlap: sysreset asserted in READ/CAPTURE/HOLD → all outputs 0 next cycle, state IDLE; start while busy → ignored, offset unaffected; start and stop in the same cycle while busy → IDLE.
